// File: rtl/types_pkg.sv
// Shared types for the rename/retire slice: rename output record and ROB entry layout.
package types_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = 4;
  localparam int PREG_W    = 7;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [PREG_W-1:0]    pd_new;
    logic [PREG_W-1:0]    pd_old;
    logic [6:0]           Opcode;
    logic [31:0]          pc;
  } rename_data;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              mispred;
    logic              is_branch;
    logic [PREG_W-1:0] pd_new;
    logic [PREG_W-1:0] pd_old;
    logic [31:0]       pc;
  } rob_entry;

  function automatic logic is_branch_op(input logic [6:0] opc);
    return opc == OPC_BRANCH;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: one alloc, one writeback, one commit per cycle; commit outputs registered (1 cycle).
// Backpressure via alloc_ready (full, flush or mispredict pulse). ROB_TAG_CHECK_EN adds sticky tag_err.
module reorder_buffer
  import types_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int PREG_W = types_pkg::PREG_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alloc_valid,
  input  rename_data        alloc_data,
  output logic              alloc_ready,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic              wb_mispredict,
`ifdef ROB_TAG_CHECK_EN
  output logic              tag_err,
`endif
  output logic              write_en,
  output logic [PREG_W-1:0] rob_data_out,
  output logic              mispredict,
  output logic              commit_valid,
  output logic [31:0]       commit_pc
);

  rob_entry          entries_q [DEPTH];
  rob_entry          entries_d [DEPTH];
  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;

  logic              write_en_q, write_en_d;
  logic [PREG_W-1:0] rob_data_out_q, rob_data_out_d;
  logic              mispredict_q, mispredict_d;
  logic              commit_valid_q, commit_valid_d;
  logic [31:0]       commit_pc_q, commit_pc_d;

  logic commit, flush_now, alloc_fire;
  rob_entry head_e;

  assign head_e      = entries_q[head_q];
  assign commit      = head_e.valid && head_e.done;
  assign flush_now   = commit && head_e.mispred;
  assign alloc_ready = (count_q != (TAG_W+1)'(DEPTH)) && !flush_now && !mispredict_q;
  assign alloc_fire  = alloc_valid && alloc_ready;

  // is_branch is tracked for debug visibility; nothing downstream consumes it yet.
  logic unused_head_branch;
  assign unused_head_branch = head_e.is_branch;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (wb_valid && entries_q[wb_tag].valid) begin
      entries_d[wb_tag].done    = 1'b1;
      entries_d[wb_tag].mispred = wb_mispredict;
    end

    if (commit) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + TAG_W'(1);
    end

    if (flush_now) begin
      // Everything younger than the branch is squashed; the branch slot was already retired above.
      for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
      tail_d  = head_q + TAG_W'(1);
      count_d = '0;
    end else begin
      if (alloc_fire) begin
        entries_d[tail_q].valid     = 1'b1;
        entries_d[tail_q].done      = 1'b0;
        entries_d[tail_q].mispred   = 1'b0;
        entries_d[tail_q].is_branch = is_branch_op(alloc_data.Opcode);
        entries_d[tail_q].pd_new    = alloc_data.pd_new;
        entries_d[tail_q].pd_old    = alloc_data.pd_old;
        entries_d[tail_q].pc        = alloc_data.pc;
        tail_d                      = tail_q + TAG_W'(1);
      end
      count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit);
    end
  end

  always_comb begin
    write_en_d     = 1'b0;
    rob_data_out_d = '0;
    commit_valid_d = commit;
    commit_pc_d    = commit ? head_e.pc : 32'd0;
    mispredict_d   = flush_now;
    // p0 on either side means no architectural mapping to give back.
    if (commit && head_e.pd_new != '0 && head_e.pd_old != '0) begin
      write_en_d     = 1'b1;
      rob_data_out_d = head_e.pd_old;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      write_en_q     <= 1'b0;
      rob_data_out_q <= '0;
      mispredict_q   <= 1'b0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
    end else begin
      entries_q      <= entries_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      write_en_q     <= write_en_d;
      rob_data_out_q <= rob_data_out_d;
      mispredict_q   <= mispredict_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
    end
  end

  assign write_en     = write_en_q;
  assign rob_data_out = rob_data_out_q;
  assign mispredict   = mispredict_q;
  assign commit_valid = commit_valid_q;
  assign commit_pc    = commit_pc_q;

`ifdef ROB_TAG_CHECK_EN
  logic tag_err_q, tag_err_d;
  logic tag_mismatch;

  assign tag_mismatch = alloc_fire && (alloc_data.rob_tag != tail_q);
  assign tag_err_d    = tag_err_q || tag_mismatch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tag_err_q <= 1'b0;
    else          tag_err_q <= tag_err_d;
  end

  assign tag_err = tag_err_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!tag_mismatch)
        else $error("reorder_buffer: rob_tag %0d allocated at tail %0d", alloc_data.rob_tag, tail_q);
    end
  end
`endif
`else
  // Slot is chosen by tail alone in this build.
  logic unused_rob_tag;
  assign unused_rob_tag = ^alloc_data.rob_tag;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: in-order retire, full, mispredict flush, stray wb, async reset.
module tb_reorder_buffer;
  import types_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       alloc_valid;
  rename_data alloc_data;
  logic       alloc_ready;
  logic       wb_valid;
  logic [3:0] wb_tag;
  logic       wb_mispredict;
  logic       write_en;
  logic [6:0] rob_data_out;
  logic       mispredict;
  logic       commit_valid;
  logic [31:0] commit_pc;
`ifdef ROB_TAG_CHECK_EN
  logic       tag_err;
`endif

  reorder_buffer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .alloc_valid  (alloc_valid),
    .alloc_data   (alloc_data),
    .alloc_ready  (alloc_ready),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .wb_mispredict(wb_mispredict),
`ifdef ROB_TAG_CHECK_EN
    .tag_err      (tag_err),
`endif
    .write_en     (write_en),
    .rob_data_out (rob_data_out),
    .mispredict   (mispredict),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Retirement tally sampled on the falling edge.
  logic tally_en = 1'b0;
  int   n_commit, n_we, n_misp, n_bad_we;
  logic [31:0] misp_pc;
  logic        misp_rdy;

  always @(negedge clk) begin
    if (tally_en) begin
      if (commit_valid) n_commit++;
      if (write_en) n_we++;
      if (write_en && (rob_data_out == 7'd70 || rob_data_out == 7'd71)) n_bad_we++;
      if (mispredict) begin
        n_misp++;
        misp_pc  = commit_pc;
        misp_rdy = alloc_ready;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset_n     = 1'b0;
    alloc_valid = 1'b0;
    wb_valid    = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic alloc(input logic [3:0] tag, input logic [6:0] pdn, input logic [6:0] pdo,
                       input logic [6:0] opc, input logic [31:0] pc);
    alloc_valid        = 1'b1;
    alloc_data.rob_tag = tag;
    alloc_data.pd_new  = pdn;
    alloc_data.pd_old  = pdo;
    alloc_data.Opcode  = opc;
    alloc_data.pc      = pc;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic wb(input logic [3:0] tag, input logic mis);
    wb_valid      = 1'b1;
    wb_tag        = tag;
    wb_mispredict = mis;
    tick();
    wb_valid      = 1'b0;
    wb_mispredict = 1'b0;
  endtask

  localparam logic [6:0] OPC_ALU = 7'b0110011;

  initial begin
    reset_n       = 1'b0;
    alloc_valid   = 1'b0;
    alloc_data    = '0;
    wb_valid      = 1'b0;
    wb_tag        = '0;
    wb_mispredict = 1'b0;
    do_reset();

    // Reset state
    check("rst_we",    32'(write_en), 0);
    check("rst_data",  32'(rob_data_out), 0);
    check("rst_misp",  32'(mispredict), 0);
    check("rst_cv",    32'(commit_valid), 0);
    check("rst_pc",    commit_pc, 0);
    check("rst_ready", 32'(alloc_ready), 1);

    // Out-of-order completion, in-order retire
    alloc(4'd0, 7'd40, 7'd33, OPC_ALU, 32'h100);
    alloc(4'd1, 7'd41, 7'd34, OPC_ALU, 32'h104);
    alloc(4'd2, 7'd42, 7'd0,  OPC_ALU, 32'h108);
    check("ooo_count", 32'(dut.count_q), 3);
    wb(4'd2, 1'b0);
    check("ooo_nocommit_a", 32'(commit_valid), 0);
    wb(4'd0, 1'b0);
    check("ooo_nocommit_b", 32'(commit_valid), 0);
    wb(4'd1, 1'b0);
    check("ooo_c0_cv",   32'(commit_valid), 1);
    check("ooo_c0_pc",   commit_pc, 32'h100);
    check("ooo_c0_we",   32'(write_en), 1);
    check("ooo_c0_data", 32'(rob_data_out), 33);
    tick();
    check("ooo_c1_cv",   32'(commit_valid), 1);
    check("ooo_c1_pc",   commit_pc, 32'h104);
    check("ooo_c1_we",   32'(write_en), 1);
    check("ooo_c1_data", 32'(rob_data_out), 34);
    tick();
    check("ooo_c2_cv",   32'(commit_valid), 1);
    check("ooo_c2_pc",   commit_pc, 32'h108);
    check("ooo_c2_we",   32'(write_en), 0);
    tick();
    check("ooo_idle_cv", 32'(commit_valid), 0);
    check("ooo_empty",   32'(dut.count_q), 0);

    // Fill to DEPTH
    do_reset();
    for (int i = 0; i < 16; i++)
      alloc(4'(i), 7'(i + 1), 7'(i + 50), OPC_ALU, 32'h200 + 32'(4 * i));
    check("full_ready", 32'(alloc_ready), 0);
    check("full_count", 32'(dut.count_q), 16);
    alloc(4'd0, 7'd99, 7'd99, OPC_ALU, 32'hdead);
    check("full_blocked_count", 32'(dut.count_q), 16);
    wb(4'd0, 1'b0);
    check("full_ready_wb", 32'(alloc_ready), 0);
    check("full_cv_wb",    32'(commit_valid), 0);
    tick();
    check("full_c_cv",    32'(commit_valid), 1);
    check("full_c_pc",    commit_pc, 32'h200);
    check("full_c_data",  32'(rob_data_out), 50);
    check("full_ready_c", 32'(alloc_ready), 1);
    check("full_count_c", 32'(dut.count_q), 15);

    // Mispredicted branch at tag 5 squashes 6 and 7
    do_reset();
    for (int i = 0; i < 5; i++)
      alloc(4'(i), 7'(i + 1), 7'(60 + i), OPC_ALU, 32'h300 + 32'(4 * i));
    alloc(4'd5, 7'd0,  7'd0,  OPC_BRANCH, 32'h314);
    alloc(4'd6, 7'd20, 7'd70, OPC_ALU,    32'h318);
    alloc(4'd7, 7'd21, 7'd71, OPC_ALU,    32'h31c);
    n_commit = 0; n_we = 0; n_misp = 0; n_bad_we = 0;
    misp_pc = '0; misp_rdy = 1'b1;
    tally_en = 1'b1;
    wb(4'd6, 1'b0);
    wb(4'd7, 1'b0);
    for (int i = 0; i < 5; i++) wb(4'(i), 1'b0);
    wb(4'd5, 1'b1);
    repeat (6) tick();
    tally_en = 1'b0;
    check("flush_commits",  32'(n_commit), 6);
    check("flush_we",       32'(n_we), 5);
    check("flush_bad_we",   32'(n_bad_we), 0);
    check("flush_misp_cyc", 32'(n_misp), 1);
    check("flush_misp_pc",  misp_pc, 32'h314);
    check("flush_misp_rdy", 32'(misp_rdy), 0);
    check("flush_count",    32'(dut.count_q), 0);
    check("flush_ready",    32'(alloc_ready), 1);
    alloc(4'd6, 7'd22, 7'd23, OPC_ALU, 32'habc);
    wb(4'd6, 1'b0);
    tick();
    check("flush_realloc_cv", 32'(commit_valid), 1);
    check("flush_realloc_pc", commit_pc, 32'habc);
    tick();

    // Stray writeback to invalid tag while empty
    wb(4'd9, 1'b0);
    check("stray_cv0", 32'(commit_valid), 0);
    tick();
    check("stray_cv1",   32'(commit_valid), 0);
    check("stray_count", 32'(dut.count_q), 0);
    check("stray_head",  32'(dut.head_q), 7);
    check("stray_tail",  32'(dut.tail_q), 7);
    check("stray_done",  32'(dut.entries_q[9].done), 0);

    // Async reset with write_en asserted
    do_reset();
    alloc(4'd0, 7'd1, 7'd10, OPC_ALU, 32'h400);
    alloc(4'd1, 7'd2, 7'd11, OPC_ALU, 32'h404);
    alloc(4'd2, 7'd3, 7'd12, OPC_ALU, 32'h408);
    wb(4'd0, 1'b0);
    wb_valid = 1'b1; wb_tag = 4'd1;
    tick();
    check("arst_pre_we", 32'(write_en), 1);
    wb_tag  = 4'd2;
    reset_n = 1'b0;
    #1;
    check("arst_we",   32'(write_en), 0);
    check("arst_data", 32'(rob_data_out), 0);
    check("arst_misp", 32'(mispredict), 0);
    check("arst_cv",   32'(commit_valid), 0);
    check("arst_pc",   commit_pc, 0);
    @(negedge clk);
    wb_valid = 1'b0;
    reset_n  = 1'b1;
    @(negedge clk);
    check("arst_head",  32'(dut.head_q), 0);
    check("arst_tail",  32'(dut.tail_q), 0);
    check("arst_count", 32'(dut.count_q), 0);
    check("arst_ready", 32'(alloc_ready), 1);

`ifdef ROB_TAG_CHECK_EN
    check("tag_err_rst", 32'(tag_err), 0);
    alloc(4'd3, 7'd1, 7'd2, OPC_ALU, 32'h500);
    check("tag_err_set", 32'(tag_err), 1);
    repeat (3) tick();
    check("tag_err_sticky", 32'(tag_err), 1);
    do_reset();
    check("tag_err_clr", 32'(tag_err), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer downstream of the rename stage.
- Accepts one renamed instruction per cycle in program order and tracks its completion from writeback.
- Retires the oldest completed entry each cycle and returns its superseded physical register (pd_old) to the rename free list.
- On a mispredicted branch reaching head, raises a one-cycle mispredict pulse and discards all younger entries.

Parameters:
- DEPTH, 16, number of entries; power of two; equals the rob_tag range.
- TAG_W, 4, log2(DEPTH); width of rob_tag.
- PREG_W, 7, physical register index width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- alloc_valid  in  1  rename output valid.
- alloc_data  in  rename_data  renamed instruction (uses rob_tag, pd_new, pd_old, Opcode, pc).
- alloc_ready  out  1  space available, no flush in progress.
- wb_valid  in  1  functional unit completion.
- wb_tag  in  TAG_W  tag of completing entry.
- wb_mispredict  in  1  completing branch was mispredicted.
- write_en  out  1  free-list return strobe.
- rob_data_out  out  PREG_W  preg returned to free list (pd_old).
- mispredict  out  1  one-cycle flush pulse to rename.
- commit_valid  out  1  an entry retired this cycle.
- commit_pc  out  32  pc of retired entry.

Behaviour:
- Reset (async, reset_n=0):
  - head=0, tail=0, count=0, all entry valid/done/mispred bits cleared.
  - write_en=0, rob_data_out=0, mispredict=0, commit_valid=0, commit_pc=0.
  - alloc_ready=1 once reset_n=1.
- Entry fields: valid, done, mispred, pd_new, pd_old, pc, is_branch.
  - is_branch = Opcode 7'b1100011.
- Allocation:
  - Occurs when alloc_valid && alloc_ready.
  - Writes entry[tail] with done=0, mispred=0, valid=1.
  - tail wraps DEPTH-1 -> 0; count+1.
- alloc_ready = (count != DEPTH) && !flush_now && !mispredict.
  - Combinational from registered state.
  - Full blocks alloc even if a commit happens the same cycle.
- Writeback:
  - wb_valid sets entry[wb_tag].done=1 and mispred=wb_mispredict.
  - Ignored if entry[wb_tag].valid=0.
  - A writeback to head is visible to commit the following cycle.
- Commit condition: entry[head].valid && entry[head].done.
  - Evaluated each cycle; at most one commit per cycle.
- On commit:
  - entry[head].valid=0; head+1 wraps; count-1.
  - Next edge: commit_valid=1, commit_pc=pc.
  - write_en=1 and rob_data_out=pd_old iff pd_new!=0 && pd_old!=0; else write_en=0.
  - Outputs are registered: 1-cycle latency from commit decision.
- flush_now = commit condition && entry[head].mispred.
  - The branch itself commits normally.
  - All other entries are invalidated; tail=head+1 (equal to the new head); count=0.
  - Next edge: mispredict=1 for exactly one cycle.
  - Discarded entries never assert write_en; rename's checkpoint restores their pd_new.
- Simultaneous events:
  - alloc plus commit in one cycle: count unchanged.
  - flush_now overrides any same-cycle writeback to other entries.
  - Same-cycle alloc is blocked by alloc_ready=0.
- Pointers are TAG_W bits with natural wrap.
  - count is TAG_W+1 bits so that full (count == DEPTH) is distinguishable from empty.
- Reset asserted mid-operation clears everything immediately; any in-flight mispredict or write_en is dropped.

Optional Feature:
- ROB_TAG_CHECK_EN defined:
  - Adds output tag_err (1 bit, sticky, cleared only by reset).
  - Set when an allocated alloc_data.rob_tag != tail; entry is still written at tail.
  - Simulation assertion fires on the same condition.
- Undefined: no tag_err port; alloc_data.rob_tag is ignored and tail alone determines the slot.

Decomposition:
- types_pkg gains:
  - rob_entry struct {valid, done, mispred, is_branch, pd_new, pd_old, pc}.
  - ROB_DEPTH=16, ROB_TAG_W=4, PREG_W=7.
  - OPC_BRANCH=7'b1100011, OPC_STORE=7'b0100011.
- rename_data is reused unchanged.
- No sub-module: a single file holding the entry array, pointers, and commit/flush logic.

Test Plan:
- Reset then allocate 3 entries (tags 0,1,2; pd_old 33,34,0); writeback tags 2,0,1 -> retire strictly in order 0,1,2; write_en pulses with 33, then 34, then none for tag 2.
- Allocate 16 with no writeback -> alloc_ready=0 after the 16th; writeback tag 0 -> one commit; alloc_ready returns to 1 the cycle after commit.
- Branch at tag 5 followed by tags 6,7; wb tag 5 with wb_mispredict=1 -> branch commits, mispredict high exactly one cycle, tags 6,7 never raise write_en, count=0, next alloc lands at tag 6.
- Writeback to an invalid tag 9 while empty -> no state change, no commit.
- Assert reset_n=0 mid-burst with write_en high -> all outputs 0 immediately; head=tail=0 after release.
- With ROB_TAG_CHECK_EN, allocate with rob_tag=3 while tail=0 -> tag_err=1, stays 1 until reset.
